ltc2195_phase_trainer: RTL and testbench
========================================

# ltc2195_phase_trainer

Automatic ENC phase calibration controller for the LTC2195 ADC interface. It sweeps the ENC phase-shifter target through a programmable range using the 0x32xx command. At each point it checks the deserialized frame word FR_out against the expected pattern, finds the longest contiguous window of good points, and programs the ADC block to the window centre. It sits between the host command bus and the LTC2195 controller's cmd inputs and arbitrates host traffic while a sweep runs.

## Interface
- PS_START, 9'h100: first phase target of the sweep.
- PS_STOP, 9'h1FF: last phase target allowed; PS_STOP ≥ PS_START is guaranteed by the integrator.
- PS_STEP, 9'h004: target increment between points; nonzero.
- PS_DEFAULT, 9'h17C: target programmed when no good point is found.
- SETTLE_CYCLES, 16'd2048: wait after each step command before checking.
- LONG_SETTLE, 16'd65535: wait after the first point and after the final set, which may be large phase jumps.
- CHECK_CYCLES, 16'd256: consecutive FR samples that must all match per point.
- FR_EXPECT, 4'b1100: expected FR_out word every clk_in cycle.
- clk_in  in  1  system clock, the same clock as the LTC2195 controller.
- rst_in  in  1  reset, asynchronous, active-high.
- start_in  in  1  one-cycle pulse; begins a sweep when idle.
- host_trig_in  in  1  host command strobe.
- host_addr_in  in  16  host command address.
- host_data_in  in  16  host command data.
- fr_in  in  4  FR_out from the LTC2195 controller.
- cmd_trig_out  out  1  command strobe to the LTC2195 controller, registered.
- cmd_addr_out  out  16  command address, registered.
- cmd_data_out  out  16  command data, registered.
- host_reject_out  out  1  one-cycle pulse when a host command is dropped.
- busy_out  out  1  high while a sweep is in progress.
- done_out  out  1  one-cycle pulse at the end of a sweep.
- fail_out  out  1  sticky; set when the last sweep found no good point, cleared by the next start.
- phase_out  out  9  phase target last programmed by the trainer.
- win_len_out  out  10  best window length of the last sweep, in points.

## Operation
- Reset values: all strobes 0, cmd_addr_out/cmd_data_out 0, busy_out 0, fail_out 0, phase_out PS_DEFAULT, win_len_out 0, state IDLE.
- States: IDLE → SET → SETTLE → CHECK → EVAL → (SET | FINAL) → FWAIT → IDLE.
- IDLE: host_trig_in is forwarded verbatim on the next cycle.
  - start_in moves to SET with value=PS_START, first=1, cur_len=0, best_len=0, and clears fail_out.
  - If start_in and host_trig_in arrive in the same cycle, start wins and the host command is rejected.
- SET: pulse cmd_trig_out for one cycle with addr 16'h3200 and data {7'b0, value}; load the settle counter with LONG_SETTLE if first, else SETTLE_CYCLES.
- SETTLE: count down to 0, then go to CHECK with the check counter set to CHECK_CYCLES and bad=0.
- CHECK: every cycle with fr_in ≠ FR_EXPECT sets bad. Exit when the counter reaches 0. There is no early exit, so timing stays deterministic.
- EVAL, good point (bad=0):
  - If cur_len==0, then cur_start=value.
  - cur_len+1.
  - If the new cur_len > best_len, best takes cur. Strict compare, so the first window wins ties.
- EVAL, bad point: cur_len=0.
- EVAL, next point: clear first. If value+PS_STEP, computed 10-bit, exceeds PS_STOP, go to FINAL; else value+=PS_STEP and go to SET.
- FINAL:
  - If best_len==0, then target=PS_DEFAULT and fail_out=1.
  - Otherwise target = best_start + (((best_len−1)·PS_STEP) >> 1), computed 19-bit and truncated to 9 bits. No overflow occurs because the result is ≤ PS_STOP.
  - Issue the command, set phase_out=target and win_len_out=best_len, and wait LONG_SETTLE in FWAIT.
- FWAIT end: pulse done_out, drop busy_out, return to IDLE.
- busy_out is high in every state except IDLE.
- Any host_trig_in while busy pulses host_reject_out on the next cycle and is never forwarded.
- start_in while busy is ignored.
- Reset mid-sweep: immediately return to reset values with no further commands. The LTC2195 block keeps whatever target it last received.

## Timing
- Host forward latency is 1 cycle; cmd_* hold their values until the next command.
- cmd_trig_out is high exactly 1 cycle per command, with at least 1 cycle between strobes.
- One point after the first takes 1 + (SETTLE_CYCLES+1) + CHECK_CYCLES + 1 cycles, ±1. An implementation must be constant per point.
- done_out is asserted in the cycle busy_out falls.

## Test plan
- Reset, then host addr 16'h3105 / data 16'h00AA → cmd_* match one cycle later; no reject.
- PS_START=0x100, PS_STOP=0x13C, PS_STEP=4; fr_in matches only for targets 0x110–0x128 → win_len_out=7, final command data 0x11C, phase_out=0x11C, fail_out=0.
- Two good windows, 0x104–0x10C (3 points) and 0x120–0x128 (3 points) → first wins, final target 0x108.
- fr_in never matches → 16 step commands, then final data 0x17C, fail_out=1, win_len_out=0; the next start clears fail_out.
- Host command and start_in mid-sweep → host_reject_out pulses once, start ignored, sweep result unchanged; same-cycle start and host in IDLE → host rejected.
- rst_in asserted in CHECK → busy_out=0 immediately, no cmd_trig_out afterward, phase_out=0x17C.

Source files
------------

// File: rtl/ltc2195_phase_trainer.sv
// Purpose: ENC phase calibration for the LTC2195. It sweeps the phase target, scores FR_out at
//          each point, and programs the centre of the longest good window.
// Latency: host commands are forwarded 1 cycle later in IDLE. A sweep point takes
//          SET + (settle+1) + CHECK_CYCLES + EVAL cycles, and this count is the same for every point.
// Backpressure: none. A host command that arrives while busy, or in the same cycle as start_in,
//          is dropped and flagged on host_reject_out.
// Ports:
//   clk_in, rst_in (async, active-high)
//   start_in                                  - sweep request
//   host_trig_in/host_addr_in/host_data_in    - host command in
//   fr_in                                     - deserialized FR word
//   cmd_trig_out/cmd_addr_out/cmd_data_out    - command out to the LTC2195 controller
//   host_reject_out, busy_out, done_out, fail_out, phase_out, win_len_out - status
module ltc2195_phase_trainer #(
  parameter logic [8:0]  PS_START      = 9'h100,
  parameter logic [8:0]  PS_STOP       = 9'h1FF,
  parameter logic [8:0]  PS_STEP       = 9'h004,
  parameter logic [8:0]  PS_DEFAULT    = 9'h17C,
  parameter logic [15:0] SETTLE_CYCLES = 16'd2048,
  parameter logic [15:0] LONG_SETTLE   = 16'd65535,
  parameter logic [15:0] CHECK_CYCLES  = 16'd256,
  parameter logic [3:0]  FR_EXPECT     = 4'b1100
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        host_trig_in,
  input  logic [15:0] host_addr_in,
  input  logic [15:0] host_data_in,
  input  logic [3:0]  fr_in,
  output logic        cmd_trig_out,
  output logic [15:0] cmd_addr_out,
  output logic [15:0] cmd_data_out,
  output logic        host_reject_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        fail_out,
  output logic [8:0]  phase_out,
  output logic [9:0]  win_len_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_SETTLE, S_CHECK, S_EVAL, S_FINAL, S_FWAIT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [8:0]  r_value;
  logic        r_first;
  logic [9:0]  r_cur_len;
  logic [8:0]  r_cur_start;
  logic [9:0]  r_best_len;
  logic [8:0]  r_best_start;
  logic [15:0] r_cnt;
  logic        r_bad;

  logic        r_cmd_trig;
  logic [15:0] r_cmd_addr;
  logic [15:0] r_cmd_data;
  logic        r_host_reject;
  logic        r_done;
  logic        r_fail;
  logic [8:0]  r_phase;
  logic [9:0]  r_win_len;

  logic        w_busy;
  logic [9:0]  w_next_val;
  logic        w_last;
  logic [9:0]  w_cur_len_inc;
  logic [8:0]  w_target;

  always_comb begin
    w_busy        = (r_state != S_IDLE);
    // The 10-bit sum catches a step that would wrap past 9'h1FF.
    w_next_val    = {1'b0, r_value} + {1'b0, PS_STEP};
    w_last        = (w_next_val > {1'b0, PS_STOP});
    w_cur_len_inc = r_cur_len + 10'd1;
    // Window centre. The result is never above PS_STOP, so truncating to 9 bits is safe.
    if (r_best_len == 10'd0) begin
      w_target = PS_DEFAULT;
    end else begin
      w_target = 9'(19'(r_best_start) +
                    (((19'(r_best_len) - 19'd1) * 19'(PS_STEP)) >> 1));
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start_in) w_state_nxt = S_SET;
      S_SET:    w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_cnt == 16'd0) w_state_nxt = S_CHECK;
      // r_cnt holds the number of samples still to take, including this cycle's sample.
      S_CHECK:  if (r_cnt <= 16'd1) w_state_nxt = S_EVAL;
      S_EVAL:   w_state_nxt = w_last ? S_FINAL : S_SET;
      S_FINAL:  w_state_nxt = S_FWAIT;
      S_FWAIT:  if (r_cnt == 16'd0) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_value       <= PS_START;
      r_first       <= 1'b0;
      r_cur_len     <= 10'd0;
      r_cur_start   <= 9'd0;
      r_best_len    <= 10'd0;
      r_best_start  <= 9'd0;
      r_cnt         <= 16'd0;
      r_bad         <= 1'b0;
      r_cmd_trig    <= 1'b0;
      r_cmd_addr    <= 16'd0;
      r_cmd_data    <= 16'd0;
      r_host_reject <= 1'b0;
      r_done        <= 1'b0;
      r_fail        <= 1'b0;
      r_phase       <= PS_DEFAULT;
      r_win_len     <= 10'd0;
    end else begin
      r_cmd_trig    <= 1'b0;
      r_host_reject <= 1'b0;
      r_done        <= 1'b0;

      // A host command is forwarded only in an idle cycle with no competing start.
      if (host_trig_in) begin
        if (w_busy || start_in) begin
          r_host_reject <= 1'b1;
        end else begin
          r_cmd_trig <= 1'b1;
          r_cmd_addr <= host_addr_in;
          r_cmd_data <= host_data_in;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_value      <= PS_START;
            r_first      <= 1'b1;
            r_cur_len    <= 10'd0;
            r_cur_start  <= 9'd0;
            r_best_len   <= 10'd0;
            r_best_start <= 9'd0;
            r_fail       <= 1'b0;
          end
        end
        S_SET: begin
          r_cmd_trig <= 1'b1;
          r_cmd_addr <= 16'h3200;
          r_cmd_data <= {7'b0, r_value};
          r_cnt      <= r_first ? LONG_SETTLE : SETTLE_CYCLES;
        end
        S_SETTLE: begin
          if (r_cnt == 16'd0) begin
            r_cnt <= CHECK_CYCLES;
            r_bad <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_CHECK: begin
          if (fr_in != FR_EXPECT) r_bad <= 1'b1;
          if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
        end
        S_EVAL: begin
          if (!r_bad) begin
            if (r_cur_len == 10'd0) r_cur_start <= r_value;
            r_cur_len <= w_cur_len_inc;
            // The compare is strict, so the earliest window keeps a tie.
            if (w_cur_len_inc > r_best_len) begin
              r_best_len   <= w_cur_len_inc;
              r_best_start <= (r_cur_len == 10'd0) ? r_value : r_cur_start;
            end
          end else begin
            r_cur_len <= 10'd0;
          end
          r_first <= 1'b0;
          if (!w_last) r_value <= w_next_val[8:0];
        end
        S_FINAL: begin
          r_cmd_trig <= 1'b1;
          r_cmd_addr <= 16'h3200;
          r_cmd_data <= {7'b0, w_target};
          r_phase    <= w_target;
          r_win_len  <= r_best_len;
          r_fail     <= (r_best_len == 10'd0);
          r_cnt      <= LONG_SETTLE;
        end
        S_FWAIT: begin
          if (r_cnt == 16'd0) begin
            r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_trig_out    = r_cmd_trig;
  assign cmd_addr_out    = r_cmd_addr;
  assign cmd_data_out    = r_cmd_data;
  assign host_reject_out = r_host_reject;
  assign busy_out        = w_busy;
  assign done_out        = r_done;
  assign fail_out        = r_fail;
  assign phase_out       = r_phase;
  assign win_len_out     = r_win_len;

endmodule

// File: tb/tb_ltc2195_phase_trainer.sv
// Purpose: self-checking bench for ltc2195_phase_trainer. A simple ADC model answers on FR
//          according to a good-point mask, and a brute-force window search gives the expected result.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_ltc2195_phase_trainer;

  localparam logic [8:0]  P_START   = 9'h100;
  localparam logic [8:0]  P_STOP    = 9'h13C;
  localparam logic [8:0]  P_STEP    = 9'h004;
  localparam logic [8:0]  P_DEFAULT = 9'h17C;
  localparam logic [15:0] P_SETTLE  = 16'd4;
  localparam logic [15:0] P_LONG    = 16'd10;
  localparam logic [15:0] P_CHECK   = 16'd8;
  localparam logic [3:0]  P_FR      = 4'b1100;
  localparam int NPTS = (int'(P_STOP) - int'(P_START)) / int'(P_STEP) + 1;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic        host_trig_in = 1'b0;
  logic [15:0] host_addr_in = 16'd0;
  logic [15:0] host_data_in = 16'd0;
  logic [3:0]  fr_in = 4'd0;
  logic        cmd_trig_out;
  logic [15:0] cmd_addr_out;
  logic [15:0] cmd_data_out;
  logic        host_reject_out;
  logic        busy_out;
  logic        done_out;
  logic        fail_out;
  logic [8:0]  phase_out;
  logic [9:0]  win_len_out;

  ltc2195_phase_trainer #(
    .PS_START(P_START), .PS_STOP(P_STOP), .PS_STEP(P_STEP), .PS_DEFAULT(P_DEFAULT),
    .SETTLE_CYCLES(P_SETTLE), .LONG_SETTLE(P_LONG), .CHECK_CYCLES(P_CHECK), .FR_EXPECT(P_FR)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .host_trig_in(host_trig_in), .host_addr_in(host_addr_in), .host_data_in(host_data_in),
    .fr_in(fr_in), .cmd_trig_out(cmd_trig_out), .cmd_addr_out(cmd_addr_out),
    .cmd_data_out(cmd_data_out), .host_reject_out(host_reject_out), .busy_out(busy_out),
    .done_out(done_out), .fail_out(fail_out), .phase_out(phase_out), .win_len_out(win_len_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ADC model and output monitor
  logic [15:0] cur_mask = 16'd0;
  logic [8:0]  adc_target = 9'd0;
  int          cyc = 0;
  int          rej_cnt = 0;
  int          done_cnt = 0;
  int          done_busy_bad = 0;
  int          b2b_cnt = 0;
  logic        prev_trig = 1'b0;
  logic [15:0] strobe_q[$];
  int          strobe_cyc[$];

  initial begin
    int idx;
    logic good;
    logic [3:0] v;
    forever begin
      @(negedge clk_in);
      cyc++;
      if (cmd_trig_out) begin
        if (prev_trig) b2b_cnt++;
        if (cmd_addr_out == 16'h3200) begin
          adc_target = cmd_data_out[8:0];
          strobe_q.push_back(cmd_data_out);
          strobe_cyc.push_back(cyc);
        end
      end
      prev_trig = cmd_trig_out;
      if (host_reject_out) rej_cnt++;
      if (done_out) begin
        done_cnt++;
        if (busy_out) done_busy_bad++;
      end
      good = 1'b0;
      if (adc_target >= P_START && adc_target <= P_STOP &&
          ((int'(adc_target) - int'(P_START)) % int'(P_STEP)) == 0) begin
        idx  = (int'(adc_target) - int'(P_START)) / int'(P_STEP);
        good = cur_mask[idx];
      end
      // A bad point misses on every fifth cycle, so any CHECK window sees at least one miss.
      if (good || (cyc % 5) != 0) begin
        fr_in = P_FR;
      end else begin
        v = 4'($urandom_range(0, 15));
        if (v == P_FR) v = 4'b0011;
        fr_in = v;
      end
    end
  end

  // Brute-force reference: scan every start/end pair and keep the first strictly longer all-good run.
  task automatic model(input logic [15:0] mask, output int blen, output int target);
    int bstart;
    bit all_good;
    blen = 0;
    bstart = 0;
    for (int s = 0; s < NPTS; s++) begin
      for (int e = s; e < NPTS; e++) begin
        all_good = 1'b1;
        for (int k = s; k <= e; k++) if (!mask[k]) all_good = 1'b0;
        if (all_good && (e - s + 1) > blen) begin
          blen = e - s + 1;
          bstart = s;
        end
      end
    end
    if (blen == 0) target = int'(P_DEFAULT);
    else target = int'(P_START) + bstart * int'(P_STEP) + ((blen - 1) * int'(P_STEP)) / 2;
  endtask

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  // mode 0: plain sweep; 1: host command and start mid-sweep; 2: host command in the same cycle as start
  task automatic run_sweep(input string tag, input logic [15:0] mask, input int mode);
    int rej0, done0, n, exp_len, exp_tgt, err, d0;
    cur_mask = mask;
    strobe_q.delete();
    strobe_cyc.delete();
    rej0 = rej_cnt;
    done0 = done_cnt;
    start_in = 1'b1;
    if (mode == 2) begin
      host_trig_in = 1'b1;
      host_addr_in = 16'h1234;
      host_data_in = 16'h5678;
    end
    tick();
    start_in = 1'b0;
    host_trig_in = 1'b0;
    chk_eq({tag, "_busy_at_start"}, 32'(busy_out), 32'd1);
    chk_eq({tag, "_fail_cleared"}, 32'(fail_out), 32'd0);
    if (mode == 2) begin
      chk_eq({tag, "_same_cycle_reject"}, 32'(host_reject_out), 32'd1);
      chk_eq({tag, "_same_cycle_no_fwd"}, 32'(cmd_trig_out), 32'd0);
    end
    if (mode == 1) begin
      repeat (30) tick();
      host_trig_in = 1'b1;
      host_addr_in = 16'h3105;
      host_data_in = 16'h0055;
      start_in = 1'b1;
      tick();
      host_trig_in = 1'b0;
      start_in = 1'b0;
    end
    n = 0;
    while (done_cnt == done0 && n < 5000) begin
      tick();
      n++;
    end
    chk_eq({tag, "_timeout"}, 32'(n < 5000), 32'd1);
    model(mask, exp_len, exp_tgt);
    chk_eq({tag, "_busy_end"}, 32'(busy_out), 32'd0);
    chk_eq({tag, "_ncmds"}, 32'(strobe_q.size()), 32'(NPTS + 1));
    if (strobe_q.size() > 0) chk_eq({tag, "_final_data"}, 32'(strobe_q[$]), 32'(exp_tgt));
    chk_eq({tag, "_phase"}, 32'(phase_out), 32'(exp_tgt));
    chk_eq({tag, "_win_len"}, 32'(win_len_out), 32'(exp_len));
    chk_eq({tag, "_fail"}, 32'(fail_out), 32'(exp_len == 0));
    chk_eq({tag, "_rejects"}, 32'(rej_cnt - rej0), 32'(mode != 0));
    err = 0;
    for (int i = 0; i + 1 < strobe_q.size(); i++)
      if (strobe_q[i] != 16'(int'(P_START) + i * int'(P_STEP))) err++;
    chk_eq({tag, "_step_data"}, 32'(err), 32'd0);
    // Intervals between step commands after the first must be identical and 15 +/- 1 cycles.
    err = 0;
    if (strobe_cyc.size() >= 3) begin
      d0 = strobe_cyc[2] - strobe_cyc[1];
      if (d0 < 14 || d0 > 16) err++;
      for (int i = 1; i + 2 < strobe_cyc.size(); i++)
        if (strobe_cyc[i + 1] - strobe_cyc[i] != d0) err++;
    end else begin
      err++;
    end
    chk_eq({tag, "_point_time"}, 32'(err), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int n, nq;
    logic [15:0] m;

    // Values held during reset
    #12;
    chk_eq("rst_busy", 32'(busy_out), 32'd0);
    chk_eq("rst_trig", 32'(cmd_trig_out), 32'd0);
    chk_eq("rst_addr", 32'(cmd_addr_out), 32'd0);
    chk_eq("rst_data", 32'(cmd_data_out), 32'd0);
    chk_eq("rst_fail", 32'(fail_out), 32'd0);
    chk_eq("rst_done", 32'(done_out), 32'd0);
    chk_eq("rst_phase", 32'(phase_out), 32'(P_DEFAULT));
    chk_eq("rst_win", 32'(win_len_out), 32'd0);
    tick();
    rst_in = 1'b0;
    repeat (2) tick();

    // Host command forwarded while idle
    host_trig_in = 1'b1;
    host_addr_in = 16'h3105;
    host_data_in = 16'h00AA;
    tick();
    host_trig_in = 1'b0;
    chk_eq("host_trig", 32'(cmd_trig_out), 32'd1);
    chk_eq("host_addr", 32'(cmd_addr_out), 32'h3105);
    chk_eq("host_data", 32'(cmd_data_out), 32'h00AA);
    chk_eq("host_no_reject", 32'(host_reject_out), 32'd0);
    tick();
    chk_eq("host_trig_one_cycle", 32'(cmd_trig_out), 32'd0);
    chk_eq("host_addr_hold", 32'(cmd_addr_out), 32'h3105);

    run_sweep("win7", 16'b0000_0111_1111_0000, 0);   // 0x110..0x128 good
    chk_eq("win7_target", 32'(phase_out), 32'h11C);
    run_sweep("two_win", 16'b0000_0111_0000_1110, 0); // 0x104..0x10C and 0x120..0x128
    chk_eq("two_win_target", 32'(phase_out), 32'h108);
    run_sweep("none", 16'h0000, 0);
    chk_eq("none_fail", 32'(fail_out), 32'd1);
    run_sweep("after_fail", 16'hFFFF, 0);
    run_sweep("disturb", 16'b0011_1100_0111_1000, 1);
    run_sweep("same_cycle", 16'b0000_0000_1100_0110, 2);
    for (int r = 0; r < 4; r++) begin
      m = 16'($urandom()) | 16'($urandom());
      run_sweep($sformatf("rand%0d", r), m, 0);
    end
    run_sweep("edges", 16'b1000_0000_0000_0001, 0);

    // Reset asserted during CHECK of the second point
    cur_mask = 16'hFFFF;
    strobe_q.delete();
    strobe_cyc.delete();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    n = 0;
    while (strobe_q.size() < 2 && n < 500) begin
      tick();
      n++;
    end
    chk_eq("rst_mid_reach", 32'(n < 500), 32'd1);
    repeat (int'(P_SETTLE) + 3) tick();
    chk_eq("rst_mid_busy_before", 32'(busy_out), 32'd1);
    rst_in = 1'b1;
    #1;
    chk_eq("rst_mid_busy", 32'(busy_out), 32'd0);
    chk_eq("rst_mid_phase", 32'(phase_out), 32'(P_DEFAULT));
    chk_eq("rst_mid_win", 32'(win_len_out), 32'd0);
    tick();
    rst_in = 1'b0;
    nq = strobe_q.size();
    repeat (60) tick();
    chk_eq("rst_mid_no_cmd", 32'(strobe_q.size()), 32'(nq));
    chk_eq("rst_mid_idle", 32'(busy_out), 32'd0);
    chk_eq("rst_mid_phase_after", 32'(phase_out), 32'(P_DEFAULT));

    chk_eq("done_with_busy_low", 32'(done_busy_bad), 32'd0);
    chk_eq("strobe_gap", 32'(b2b_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
